// File: rtl/mem_port_arbiter.sv
// Shared single-word memory port arbiter for the fetch and data request ports.
// D has priority in IDLE; i_resp is held until the pipeline advances.
module mem_port_arbiter #(
    parameter int WIDTH = 32,
    parameter int BE_W  = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_read,
    input  logic [WIDTH-1:0] i_addr,
    output logic [WIDTH-1:0] i_rdata,
    output logic             i_resp,
    input  logic             d_read,
    input  logic             d_write,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    input  logic [BE_W-1:0]  d_byte_enable,
    output logic [WIDTH-1:0] d_rdata,
    output logic             d_resp,
    output logic             mem_read,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [BE_W-1:0]  mem_byte_enable,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        I_WAIT,
        D_WAIT
    } state_t;

    state_t           state;
    logic             i_hold;
    logic             d_done;
    logic [WIDTH-1:0] i_tag;

    logic d_req;
    logic advance;
    logic d_grant;
    logic i_grant;
    logic i_cpl;

    assign d_req   = d_read | d_write;
    assign advance = i_hold & (~d_req | d_resp | d_done);
    assign i_resp  = i_hold;

    // d_done and a live d_resp both mark the current D op as already served
    assign d_grant = (state == IDLE) & d_req & ~d_done & ~d_resp;
    assign i_grant = (state == IDLE) & ~d_grant & i_read & ~i_hold;

    // Fetch data is kept only if the pipeline still wants the same address
    assign i_cpl = (state == I_WAIT) & mem_resp & i_read & (i_addr == i_tag);

    // Arbitration FSM with registered memory-side and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            i_hold          <= 1'b0;
            d_done          <= 1'b0;
            i_tag           <= '0;
            i_rdata         <= '0;
            d_rdata         <= '0;
            d_resp          <= 1'b0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
        end else begin
            d_resp <= 1'b0;
            i_hold <= (i_hold | i_cpl) & ~advance;
            d_done <= (d_done | d_resp) & ~advance;
            unique case (state)
                IDLE: begin
                    if (d_grant) begin
                        mem_read  <= d_read;
                        mem_write <= d_write;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_byte_enable <= d_write ? d_byte_enable : '1;
                        state     <= D_WAIT;
                    end else if (i_grant) begin
                        mem_read        <= 1'b1;
                        mem_addr        <= i_addr;
                        mem_byte_enable <= '1;
                        i_tag           <= i_addr;
                        state           <= I_WAIT;
                    end
                end
                I_WAIT: begin
                    if (mem_resp) begin
                        mem_read <= 1'b0;
                        state    <= IDLE;
                        if (i_cpl) begin
                            i_rdata <= mem_rdata;
                        end
                    end
                end
                D_WAIT: begin
                    if (mem_resp) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        d_resp    <= 1'b1;
                        state     <= IDLE;
                        if (mem_read) begin
                            d_rdata <= mem_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a stepwise pipeline model drives
// both ports, a latency-randomized memory answers, a reference memory checks.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_read;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byte_enable;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] dev  [128];
    logic [31:0] refm [128];

    int          d_txn;
    int          cur_op;
    logic [31:0] cur_da;
    logic [31:0] cur_wd;
    logic [3:0]  cur_be;

    mem_port_arbiter #(.WIDTH(32), .BE_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_read          (i_read),
        .i_addr          (i_addr),
        .i_rdata         (i_rdata),
        .i_resp          (i_resp),
        .d_read          (d_read),
        .d_write         (d_write),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_byte_enable   (d_byte_enable),
        .d_rdata         (d_rdata),
        .d_resp          (d_resp),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "mem_read"}, 32'(mem_read), 32'd0);
        chk({pfx, "mem_write"}, 32'(mem_write), 32'd0);
        chk({pfx, "mem_addr"}, mem_addr, 32'd0);
        chk({pfx, "mem_wdata"}, mem_wdata, 32'd0);
        chk({pfx, "mem_be"}, 32'(mem_byte_enable), 32'd0);
        chk({pfx, "i_rdata"}, i_rdata, 32'd0);
        chk({pfx, "i_resp"}, 32'(i_resp), 32'd0);
        chk({pfx, "d_rdata"}, d_rdata, 32'd0);
        chk({pfx, "d_resp"}, 32'(d_resp), 32'd0);
    endtask

    // Memory device: accepts one request, answers 1..3 cycles later
    initial begin
        logic       busy;
        int         cnt;
        logic [6:0] ridx;
        busy      = 1'b0;
        cnt       = 0;
        ridx      = '0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_resp) begin
                mem_resp = 1'b0;
            end else if (busy) begin
                if (cnt == 0) begin
                    mem_resp  = 1'b1;
                    mem_rdata = dev[ridx];
                    busy      = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (mem_read || mem_write) begin
                chk("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
                ridx = mem_addr[8:2];
                if (mem_read) chk("rd_be", 32'(mem_byte_enable), 32'hf);
                if (mem_write || mem_addr >= 32'h100) begin
                    d_txn++;
                    chk("d_addr", mem_addr, cur_da);
                    chk("d_op_write", 32'(mem_write), 32'(cur_op == 2));
                    if (mem_write) begin
                        chk("d_wdata", mem_wdata, cur_wd);
                        chk("d_be", 32'(mem_byte_enable), 32'(cur_be));
                        for (int b = 0; b < 4; b++)
                            if (mem_byte_enable[b])
                                dev[ridx][8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                end
                busy = 1'b1;
                cnt  = $urandom_range(0, 2);
            end
        end
    end

    // Pipeline model: one fetch plus an optional D op per step
    initial begin
        logic [31:0] fa;
        logic [31:0] da;
        logic [31:0] wd;
        logic [3:0]  be;
        int          op;
        int          redir;
        int          dcnt;
        int          nstray;
        logic        adv;
        logic        seen;

        for (int i = 0; i < 128; i++) begin
            dev[i]  = $urandom;
            refm[i] = dev[i];
        end
        d_txn  = 0;
        cur_op = 0;
        cur_da = '0;
        cur_wd = '0;
        cur_be = '0;
        rst = 1'b1;
        i_read = 1'b0;
        i_addr = '0;
        d_read = 1'b0;
        d_write = 1'b0;
        d_addr = '0;
        d_wdata = '0;
        d_byte_enable = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("rst_");
        rst = 1'b0;

        // Abort a load mid-flight; the late memory answer must be ignored
        @(negedge clk);
        cur_op = 1;
        cur_da = 32'h140;
        d_addr = 32'h140;
        d_read = 1'b1;
        seen   = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = mem_read;
        end
        chk("dwait_reached", 32'(seen), 32'd1);
        rst    = 1'b1;
        d_read = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_mid_");
        rst    = 1'b0;
        nstray = 0;
        repeat (6) begin
            @(negedge clk);
            if (d_resp) nstray++;
        end
        chk("stray_resp", 32'(nstray), 32'd0);
        chk("idle_after", 32'(mem_read | mem_write), 32'd0);
        d_txn = 0;

        for (int s = 0; s < 150; s++) begin
            fa = 32'($urandom_range(0, 63)) * 4;
            op = $urandom_range(0, 2);
            da = 32'h100 + 32'($urandom_range(0, 15)) * 4;
            wd = $urandom;
            be = 4'($urandom_range(1, 15));
            cur_op = op;
            cur_da = da;
            cur_wd = wd;
            cur_be = be;
            i_read = 1'b1;
            i_addr = fa;
            d_read = (op == 1);
            d_write = (op == 2);
            d_addr = da;
            d_wdata = wd;
            d_byte_enable = be;
            redir = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            dcnt = 0;
            adv  = 1'b0;
            for (int cyc = 1; cyc <= 300 && !adv; cyc++) begin
                @(negedge clk);
                if (cyc == 1) chk("i_resp_drop", 32'(i_resp), 32'd0);
                if (d_resp) begin
                    dcnt++;
                    if (op == 1) chk("load_data", d_rdata, refm[da[8:2]]);
                end
                if (i_resp && (op == 0 || dcnt > 0)) begin
                    adv = 1'b1;
                end else if (cyc == redir && !i_resp) begin
                    fa = 32'($urandom_range(0, 63)) * 4;
                    i_addr = fa;
                end
            end
            if (!adv) chk("advance_timeout", 32'd0, 32'd1);
            chk("i_data", i_rdata, refm[fa[8:2]]);
            chk("d_resp_cnt", 32'(dcnt), 32'(op != 0));
            chk("d_txn_cnt", 32'(d_txn), 32'(op != 0));
            if (op == 2)
                for (int b = 0; b < 4; b++)
                    if (be[b]) refm[da[8:2]][8*b +: 8] = wd[8*b +: 8];
            d_txn = 0;
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
